// File: rtl/riscv_operand_fetch_if.sv
// riscv_operand_fetch_if
//   Bundles the issue, operand, writeback and register-file signals of the
//   RISC-V operand-fetch sequencer.
//   slave  : view taken by riscv_operand_fetch.
//   master : view taken by the environment (decode/execute/register file).
//   Issue   : iss_valid/iss_ready, iss_rs1, iss_rs2, iss_rd, iss_wb
//   Operand : op_valid/op_ready, op_a, op_b, op_rd
//   Wback   : wb_valid, wb_rd, wb_data, wb_err
//   RF      : rf_cs, rf_ra, rf_rb, rf_rd, rf_wen, rf_data (request), rf_a, rf_b (read data)
interface riscv_operand_fetch_if #(
  parameter int unsigned XLEN = 32
);
  logic            iss_valid;
  logic            iss_ready;
  logic [4:0]      iss_rs1;
  logic [4:0]      iss_rs2;
  logic [4:0]      iss_rd;
  logic            iss_wb;

  logic            op_valid;
  logic            op_ready;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      op_rd;

  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            wb_err;

  logic            rf_cs;
  logic [4:0]      rf_ra;
  logic [4:0]      rf_rb;
  logic [4:0]      rf_rd;
  logic            rf_wen;
  logic [XLEN-1:0] rf_data;
  logic [XLEN-1:0] rf_a;
  logic [XLEN-1:0] rf_b;

  modport slave (
    input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_wb,
    output iss_ready,
    output op_valid, op_a, op_b, op_rd,
    input  op_ready,
    input  wb_valid, wb_rd, wb_data,
    output wb_err,
    output rf_cs, rf_ra, rf_rb, rf_rd, rf_wen, rf_data,
    input  rf_a, rf_b
  );

  modport master (
    output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_wb,
    input  iss_ready,
    input  op_valid, op_a, op_b, op_rd,
    output op_ready,
    output wb_valid, wb_rd, wb_data,
    input  wb_err,
    input  rf_cs, rf_ra, rf_rb, rf_rd, rf_wen, rf_data,
    output rf_a, rf_b
  );
endinterface

// File: rtl/riscv_operand_fetch.sv
// riscv_operand_fetch
//   Operand-fetch and writeback sequencer in front of a RISC-V register file
//   with registered reads. Issue requests read both sources (S1), the read
//   data is registered into the operand stage (OUT) one cycle later. A busy
//   scoreboard stalls RAW/WAW hazards against outstanding writebacks; x0
//   always reads as zero and is never marked busy.
//   Ports:
//     clk  : clock, rising edge
//     rstn : asynchronous active-low reset
//     bus  : riscv_operand_fetch_if.slave (issue, operand, writeback, RF)
//   Optional feature macro: OPFETCH_FWD_EN
//     When defined, a busy source being written back in the same cycle is
//     forwarded from wb_data instead of stalling. WAW still stalls.
module riscv_operand_fetch #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input logic                  clk,
  input logic                  rstn,
  riscv_operand_fetch_if.slave bus
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  logic            s1_valid;
  logic [4:0]      s1_rs1;
  logic [4:0]      s1_rs2;
  logic [4:0]      s1_rd;

  logic            op_valid_q;
  logic [XLEN-1:0] op_a_q;
  logic [XLEN-1:0] op_b_q;
  logic [4:0]      op_rd_q;
  logic            wb_err_q;

  logic            rs1_stall;
  logic            rs2_stall;
  logic            hazard;
  logic            iss_ready_int;
  logic            iss_fire;
  logic            wb_fire;
  logic            wb_set_err;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] opa_nxt;
  logic [XLEN-1:0] opb_nxt;

`ifdef OPFETCH_FWD_EN
  logic            fwd_a;
  logic            fwd_b;
  logic            s1_fwd_a;
  logic            s1_fwd_b;
  logic [XLEN-1:0] s1_fwd_data;
`endif

  // Hazard detection and handshake
  always_comb begin
`ifdef OPFETCH_FWD_EN
    fwd_a     = bus.wb_valid && (bus.wb_rd == bus.iss_rs1) && (bus.iss_rs1 != '0);
    fwd_b     = bus.wb_valid && (bus.wb_rd == bus.iss_rs2) && (bus.iss_rs2 != '0);
    rs1_stall = busy[bus.iss_rs1] && !fwd_a;
    rs2_stall = busy[bus.iss_rs2] && !fwd_b;
`else
    rs1_stall = busy[bus.iss_rs1];
    rs2_stall = busy[bus.iss_rs2];
`endif
    hazard        = rs1_stall || rs2_stall || (bus.iss_wb && busy[bus.iss_rd]);
    // Gated by rstn so every output reads 0 while reset is held.
    iss_ready_int = rstn && !hazard && !s1_valid && (!op_valid_q || bus.op_ready);
    iss_fire      = bus.iss_valid && iss_ready_int;
    wb_fire       = rstn && bus.wb_valid;
    wb_set_err    = wb_fire && (bus.wb_rd != '0) && !busy[bus.wb_rd];
  end

  // Scoreboard next state: clear on writeback, set on issue; set wins.
  always_comb begin
    busy_nxt = busy;
    if (wb_fire) busy_nxt[bus.wb_rd] = 1'b0;
    if (iss_fire && bus.iss_wb && (bus.iss_rd != '0)) busy_nxt[bus.iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Operand selection for the S1 -> OUT transfer
  always_comb begin
    src_a = bus.rf_a;
    src_b = bus.rf_b;
`ifdef OPFETCH_FWD_EN
    if (s1_fwd_a) src_a = s1_fwd_data;
    if (s1_fwd_b) src_b = s1_fwd_data;
`endif
    opa_nxt = (s1_rs1 == '0) ? '0 : src_a;
    opb_nxt = (s1_rs2 == '0) ? '0 : src_b;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy        <= '0;
      s1_valid    <= 1'b0;
      s1_rs1      <= '0;
      s1_rs2      <= '0;
      s1_rd       <= '0;
      op_valid_q  <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_rd_q     <= '0;
      wb_err_q    <= 1'b0;
`ifdef OPFETCH_FWD_EN
      s1_fwd_a    <= 1'b0;
      s1_fwd_b    <= 1'b0;
      s1_fwd_data <= '0;
`endif
    end else begin
      busy <= busy_nxt;
      if (wb_set_err) wb_err_q <= 1'b1;

      // Issue cannot fire while S1 is occupied, so S1 lives exactly one cycle.
      if (iss_fire) begin
        s1_valid    <= 1'b1;
        s1_rs1      <= bus.iss_rs1;
        s1_rs2      <= bus.iss_rs2;
        s1_rd       <= bus.iss_rd;
`ifdef OPFETCH_FWD_EN
        s1_fwd_a    <= fwd_a;
        s1_fwd_b    <= fwd_b;
        s1_fwd_data <= bus.wb_data;
`endif
      end else begin
        s1_valid <= 1'b0;
      end

      // Issue required OUT free or draining, so S1 always finds room here.
      if (s1_valid) begin
        op_valid_q <= 1'b1;
        op_a_q     <= opa_nxt;
        op_b_q     <= opb_nxt;
        op_rd_q    <= s1_rd;
      end else if (bus.op_ready) begin
        op_valid_q <= 1'b0;
      end
    end
  end

  assign bus.iss_ready = iss_ready_int;
  assign bus.op_valid  = op_valid_q;
  assign bus.op_a      = op_a_q;
  assign bus.op_b      = op_b_q;
  assign bus.op_rd     = op_rd_q;
  assign bus.wb_err    = wb_err_q;

  // Issue and writeback share one RF request cycle.
  assign bus.rf_cs   = iss_fire || wb_fire;
  assign bus.rf_ra   = iss_fire ? bus.iss_rs1 : '0;
  assign bus.rf_rb   = iss_fire ? bus.iss_rs2 : '0;
  assign bus.rf_rd   = wb_fire ? bus.wb_rd : '0;
  assign bus.rf_data = wb_fire ? bus.wb_data : '0;
  assign bus.rf_wen  = wb_fire && (bus.wb_rd != '0);

endmodule

// File: tb/tb_riscv_operand_fetch.sv
module tb_riscv_operand_fetch;
  localparam int unsigned XLEN = 32;
  localparam int TMO = 40;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  riscv_operand_fetch_if #(.XLEN(XLEN)) bus ();

  riscv_operand_fetch #(.XLEN(XLEN), .NREG(32)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Register file model: registered read, read-during-write returns old data.
  // x0 holds garbage on purpose so the DUT's zeroing of x0 reads is visible.
  logic [31:0] mem [32];
  logic        mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h1000 + i;
      mem[0]   <= 32'hDEAD_0000;
      bus.rf_a <= '0;
      bus.rf_b <= '0;
      mem_init <= 1'b1;
    end else if (bus.rf_cs) begin
      if (bus.rf_wen) mem[bus.rf_rd] <= bus.rf_data;
      bus.rf_a <= mem[bus.rf_ra];
      bus.rf_b <= mem[bus.rf_rb];
    end
  end

  // Monitor: compare every accepted operand pair against the scoreboard.
  always @(negedge clk) begin
    if (rstn && bus.op_valid && bus.op_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL op_unexpected: got a=%h b=%h rd=%0d expected none", bus.op_a, bus.op_b, bus.op_rd);
      end else begin
        mon_e = q.pop_front();
        chk("op_a", bus.op_a, mon_e.a);
        chk("op_b", bus.op_b, mon_e.b);
        chk("op_rd", {27'd0, bus.op_rd}, {27'd0, mon_e.rd});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic wb, input logic [31:0] ea, input logic [31:0] eb);
    int   n;
    exp_t e;
    n = 0;
    @(posedge clk); #1;
    bus.iss_valid = 1'b1;
    bus.iss_rs1   = rs1;
    bus.iss_rs2   = rs2;
    bus.iss_rd    = rd;
    bus.iss_wb    = wb;
    forever begin
      @(negedge clk);
      if (bus.iss_ready) break;
      n++;
      if (n > TMO) begin
        checks++;
        errors++;
        $display("FAIL issue_timeout: got no accept expected accept rs1=%0d rs2=%0d", rs1, rs2);
        break;
      end
    end
    if (n <= TMO) begin
      e.a  = ea;
      e.b  = eb;
      e.rd = rd;
      q.push_back(e);
    end
    @(posedge clk); #1;
    bus.iss_valid = 1'b0;
  endtask

  task automatic wback(input logic [4:0] rd, input logic [31:0] data);
    @(posedge clk); #1;
    bus.wb_valid = 1'b1;
    bus.wb_rd    = rd;
    bus.wb_data  = data;
  endtask

  initial begin
    bus.iss_valid = 1'b0;
    bus.iss_rs1   = '0;
    bus.iss_rs2   = '0;
    bus.iss_rd    = '0;
    bus.iss_wb    = 1'b0;
    bus.op_ready  = 1'b1;
    bus.wb_valid  = 1'b0;
    bus.wb_rd     = '0;
    bus.wb_data   = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_iss_ready", {31'd0, bus.iss_ready}, 32'd0);
    chk("rst_op_valid", {31'd0, bus.op_valid}, 32'd0);
    chk("rst_op_a", bus.op_a, 32'd0);
    chk("rst_wb_err", {31'd0, bus.wb_err}, 32'd0);
    chk("rst_rf_cs", {31'd0, bus.rf_cs}, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_iss_ready", {31'd0, bus.iss_ready}, 32'd1);

    // x0 sources and 2-cycle latency
    @(posedge clk); #1;
    bus.iss_valid = 1'b1;
    bus.iss_rs1 = 5'd0; bus.iss_rs2 = 5'd0; bus.iss_rd = 5'd1; bus.iss_wb = 1'b0;
    @(negedge clk);
    chk("acc_iss_ready", {31'd0, bus.iss_ready}, 32'd1);
    chk("acc_rf_cs", {31'd0, bus.rf_cs}, 32'd1);
    chk("acc_rf_ra", {27'd0, bus.rf_ra}, 32'd0);
    q.push_back('{a: 32'd0, b: 32'd0, rd: 5'd1});
    @(posedge clk); #1;
    bus.iss_valid = 1'b0;
    @(negedge clk);
    chk("lat_n1_op_valid", {31'd0, bus.op_valid}, 32'd0);
    chk("lat_n1_iss_ready", {31'd0, bus.iss_ready}, 32'd0);
    @(negedge clk);
    chk("lat_n2_op_valid", {31'd0, bus.op_valid}, 32'd1);

    // Writeback to a non-busy register: sticky error, data lands in RF
    wback(5'd5, 32'h0000_1234);
    @(negedge clk);
    chk("wb5_rf_wen", {31'd0, bus.rf_wen}, 32'd1);
    chk("wb5_rf_rd", {27'd0, bus.rf_rd}, 32'd5);
    @(posedge clk); #1;
    bus.wb_valid = 1'b0;
    @(negedge clk);
    chk("wb_err_set", {31'd0, bus.wb_err}, 32'd1);
    issue(5'd5, 5'd3, 5'd2, 1'b0, 32'h0000_1234, 32'h0000_1003);

    // RAW stall on x7 until its writeback
    issue(5'd1, 5'd2, 5'd7, 1'b1, 32'h0000_1001, 32'h0000_1002);
    fork
      issue(5'd7, 5'd0, 5'd8, 1'b0, 32'h0000_BEEF, 32'd0);
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("raw_stall", {31'd0, bus.iss_ready}, 32'd0);
        wback(5'd7, 32'h0000_BEEF);
        @(negedge clk);
`ifdef OPFETCH_FWD_EN
        chk("raw_wb_cycle_fwd", {31'd0, bus.iss_ready}, 32'd1);
`else
        chk("raw_wb_cycle", {31'd0, bus.iss_ready}, 32'd0);
`endif
        @(posedge clk); #1;
        bus.wb_valid = 1'b0;
      end
    join
    chk("wb_err_sticky", {31'd0, bus.wb_err}, 32'd1);

    // Back-pressure: operands hold while writebacks run
    repeat (3) @(posedge clk);
    #1 bus.op_ready = 1'b0;
    issue(5'd3, 5'd4, 5'd9, 1'b0, 32'h0000_1003, 32'h0000_1004);
    for (int unsigned i = 0; i < 5; i++) begin
      wback((i % 2 == 0) ? 5'd10 : 5'd11, (i % 2 == 0) ? 32'h55 : 32'h66);
      @(negedge clk);
      chk("hold_op_valid", {31'd0, bus.op_valid}, 32'd1);
      chk("hold_op_a", bus.op_a, 32'h0000_1003);
      chk("hold_op_b", bus.op_b, 32'h0000_1004);
      chk("hold_iss_ready", {31'd0, bus.iss_ready}, 32'd0);
    end
    @(posedge clk); #1;
    bus.wb_valid = 1'b0;
    bus.op_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("op_drop", {31'd0, bus.op_valid}, 32'd0);

    // Writeback to x0 does not write; x0 still reads zero
    wback(5'd0, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("x0_rf_wen", {31'd0, bus.rf_wen}, 32'd0);
    chk("x0_rf_cs", {31'd0, bus.rf_cs}, 32'd1);
    @(posedge clk); #1;
    bus.wb_valid = 1'b0;
    issue(5'd0, 5'd10, 5'd14, 1'b0, 32'd0, 32'h55);

`ifdef OPFETCH_FWD_EN
    // Forward: rs2 busy and written in the same cycle
    repeat (3) @(posedge clk);
    issue(5'd0, 5'd0, 5'd12, 1'b1, 32'd0, 32'd0);
    @(posedge clk); #1;
    bus.iss_valid = 1'b1;
    bus.iss_rs1 = 5'd0; bus.iss_rs2 = 5'd12; bus.iss_rd = 5'd15; bus.iss_wb = 1'b0;
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd12; bus.wb_data = 32'h0000_CAFE;
    @(negedge clk);
    chk("fwd_accept", {31'd0, bus.iss_ready}, 32'd1);
    if (bus.iss_ready) q.push_back('{a: 32'd0, b: 32'h0000_CAFE, rd: 5'd15});
    @(posedge clk); #1;
    bus.iss_valid = 1'b0;
    bus.wb_valid  = 1'b0;
`endif

    // Reset mid-S1 discards the pipeline and the scoreboard
    repeat (3) @(posedge clk);
    #1;
    bus.iss_valid = 1'b1;
    bus.iss_rs1 = 5'd1; bus.iss_rs2 = 5'd2; bus.iss_rd = 5'd13; bus.iss_wb = 1'b1;
    @(negedge clk);
    chk("pre_rst_accept", {31'd0, bus.iss_ready}, 32'd1);
    @(posedge clk); #1;
    bus.iss_valid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("midrst_op_valid", {31'd0, bus.op_valid}, 32'd0);
    chk("midrst_iss_ready", {31'd0, bus.iss_ready}, 32'd0);
    chk("midrst_wb_err", {31'd0, bus.wb_err}, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    bus.iss_rs1 = 5'd13; bus.iss_rs2 = 5'd0; bus.iss_wb = 1'b0;
    @(negedge clk);
    chk("midrst_busy_clear", {31'd0, bus.iss_ready}, 32'd1);
    issue(5'd13, 5'd0, 5'd0, 1'b0, 32'h0000_100D, 32'd0);

    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
